mem_lsu: RTL
============

Name: mem_lsu

Overview:
Parametrised load/store memory stage. It replaces single-cycle combinational memory access with a registered request/acknowledge bus interface. It sits between execute and writeback and performs alignment checks, byte-strobe and store-data lane generation, load extraction with sign/zero extension, and bus-error/timeout fault reporting. While a transfer is outstanding it stalls upstream through `busy`.

Parameters:
- DATA_WIDTH, 32, bus and register width; 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT, 0, cycles in WAIT without ack before an access fault; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  instruction valid from execute.
- exception_in  in  1  upstream exception pending.
- ecause_in  in  4  upstream exception cause.
- load_in  in  1  instruction is a load.
- store_in  in  1  instruction is a store.
- size_in  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- signed_in  in  1  sign-extend the load result.
- addr_in  in  ADDR_WIDTH  byte address.
- store_data_in  in  DATA_WIDTH  store value, right-aligned.
- rd_address_in  in  5  destination register.
- invalidate  in  1  flush from hazard unit.
- stall_in  in  1  writeback cannot accept a result.
- busy  out  1  stage occupied; upstream must hold.
- bus_req  out  1  request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_WIDTH  address aligned down to DATA_WIDTH/8.
- bus_wdata  out  DATA_WIDTH  write data, lane-shifted.
- bus_strb  out  DATA_WIDTH/8  byte enables.
- bus_ack  in  1  request completed.
- bus_err  in  1  valid with ack; access failed.
- bus_rdata  in  DATA_WIDTH  read data, valid with ack.
- valid_out  out  1  result valid to writeback.
- load_data_out  out  DATA_WIDTH  extracted, extended load data.
- rd_address_out  out  5  destination register.
- exception_out  out  1  exception flag.
- ecause_out  out  4  exception cause.

Behaviour:
- Reset: state IDLE. bus_req, bus_we, valid_out and exception_out are 0. bus_addr, bus_wdata, bus_strb, load_data_out, rd_address_out, ecause_out and the timeout counter are 0.
- States:
  - IDLE: no transfer outstanding.
  - WAIT: bus_req is held high until ack or timeout.
  - HOLD: result completed but stall_in is high.
- busy = (state != IDLE).
- Alignment: off = addr_in[log2(DATA_WIDTH/8)-1:0].
  - Byte is always aligned.
  - Half requires off[0]=0.
  - Word requires off[1:0]=0.
  - Dword requires off[2:0]=0 and DATA_WIDTH=64; with DATA_WIDTH=32 a dword access is always misaligned.
- Accept condition, in IDLE with stall_in=0: valid_in && !invalidate && !exception_in && (load_in||store_in) && aligned.
- On accept:
  - Register bus_req=1, bus_we=store_in, bus_addr, and strobe = (1,3,F,FF for byte/half/word/dword) << off.
  - bus_wdata = store_data_in << (8*off).
  - Enter WAIT; bus_req is first high the cycle after accept.
- Non-accepted instructions in IDLE with stall_in=0 pass through with 1-cycle latency:
  - valid_out <= valid_in && !invalidate.
  - A misaligned load sets exception_out=1, ecause 4; a misaligned store sets ecause 6.
  - An upstream exception passes through exception_in/ecause_in unchanged and has priority over misalignment.
  - No bus request is made in any of these cases.
- WAIT:
  - bus_req, bus_we, bus_addr, bus_wdata and bus_strb stay stable until bus_ack.
  - On the ack cycle: bus_req <= 0, and load_data_out <= extract(bus_rdata >> 8*off, size) extended per signed_in.
  - bus_err=1 with ack sets exception_out=1, ecause 5 for a load or 7 for a store.
  - Go to IDLE with valid_out=1 if stall_in=0, else HOLD.
  - Latency from accept to valid_out is k+1 cycles, where the ack arrives k cycles after bus_req first rises.
- Timeout, when TIMEOUT>0:
  - The counter clears on WAIT entry and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT: drop bus_req and complete as an access fault (ecause 5 or 7).
  - An ack in the same cycle as the timeout wins.
- HOLD: outputs are frozen. When stall_in falls, drive valid_out=1 for one cycle and return to IDLE.
- stall_in in IDLE: all outputs hold and no new accept occurs.
- invalidate while in WAIT or HOLD:
  - The bus transfer is not aborted; the block waits for ack or timeout.
  - The completing result is issued with valid_out=0 and exception_out=0.
  - The flushed flag is sticky until the block returns to IDLE.
- valid_out is a single-cycle pulse per instruction and never re-asserts while outputs are held.
- bus_ack or bus_err arriving outside WAIT is ignored.
- Reset asserted mid-transfer: immediate return to IDLE with bus_req=0; any in-flight ack is ignored after reset.

Test Plan:
1. Aligned word load, addr 0x1004, DATA_WIDTH 32, ack after 3 cycles, rdata 0xDEADBEEF -> bus_strb 0xF, bus_req high for 3 cycles, valid_out 4 cycles after accept, load_data_out 0xDEADBEEF, busy high throughout WAIT.
2. Signed byte load at addr 0x1003, rdata 0x80FFFFFF -> bus_strb 0x8, bus_addr 0x1000, load_data_out 0xFFFFFF80. With signed_in=0 -> 0x00000080.
3. Half store at addr 0x2002, data 0x1234 -> bus_we 1, bus_strb 0xC, bus_wdata 0x12340000. Half store at 0x2001 -> no bus_req, exception_out 1, ecause 6, next cycle.
4. TIMEOUT=4, load with no ack -> bus_req drops after 4 WAIT cycles, exception_out 1, ecause 5. bus_err with ack on a store -> ecause 7.
5. stall_in held high when ack arrives -> state HOLD, valid_out 0 until stall_in falls, then exactly one valid_out pulse with data unchanged.
6. invalidate during WAIT, then ack -> valid_out stays 0, no exception. DATA_WIDTH=64 dword load at 0x...8 -> strb 0xFF, 64-bit data returned intact.

Source files
------------

// File: rtl/mem_lsu_if.sv
// Request/acknowledge bus between the load/store stage and memory.
// The LSU drives the request side; memory returns ack/err/rdata.
interface mem_lsu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    bus_req;
  logic                    bus_we;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic [DATA_WIDTH-1:0]   bus_wdata;
  logic [DATA_WIDTH/8-1:0] bus_strb;
  logic                    bus_ack;
  logic                    bus_err;
  logic [DATA_WIDTH-1:0]   bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_strb,
    input  bus_ack, bus_err, bus_rdata
  );
  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_strb,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store memory stage: alignment check, lane steering, registered bus
// request with optional timeout, and load extraction/extension.
module mem_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic                  exception_in,
  input  logic [3:0]            ecause_in,
  input  logic                  load_in,
  input  logic                  store_in,
  input  logic [1:0]            size_in,
  input  logic                  signed_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] store_data_in,
  input  logic [4:0]            rd_address_in,
  input  logic                  invalidate,
  input  logic                  stall_in,
  output logic                  busy,
  mem_lsu_if.master             bus,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] load_data_out,
  output logic [4:0]            rd_address_out,
  output logic                  exception_out,
  output logic [3:0]            ecause_out
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int OW = $clog2(SW);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state;

  logic [OW-1:0]         off, off_r;
  logic [1:0]            size_r;
  logic                  sgn_r, st_r, flushed;
  logic [4:0]            rd_r;
  logic [TW-1:0]         tcnt;
  logic                  aligned, mem_op, accept, pass_exc;
  logic [3:0]            pass_cause;
  logic [SW-1:0]         strb_base;
  logic [DATA_WIDTH-1:0] sh, mask, ld_ext;
  logic                  sbit, tmo, done, fault, fl_now;

  assign busy   = (state != IDLE);
  assign off    = addr_in[OW-1:0];
  assign mem_op = load_in || store_in;

  always_comb begin
    aligned   = 1'b1;
    strb_base = SW'(8'h01);
    case (size_in)
      2'd0: begin aligned = 1'b1;             strb_base = SW'(8'h01); end
      2'd1: begin aligned = (off[0] == 1'b0);  strb_base = SW'(8'h03); end
      2'd2: begin aligned = (off[1:0] == 2'b0); strb_base = SW'(8'h0F); end
      default: begin aligned = (DATA_WIDTH == 64) && (off == '0); strb_base = SW'(8'hFF); end
    endcase
  end

  assign accept   = valid_in && !invalidate && !exception_in && mem_op && aligned;
  // Upstream exceptions outrank our own misalignment fault.
  assign pass_exc = valid_in && !invalidate && (exception_in || (mem_op && !aligned));
  assign pass_cause = exception_in ? ecause_in : (load_in ? 4'd4 : 4'd6);

  // Read data is shifted back down to bit 0 before sign/zero extension.
  assign sh = bus.bus_rdata >> {off_r, 3'b000};
  always_comb begin
    mask = '1;
    sbit = sh[DATA_WIDTH-1];
    case (size_r)
      2'd0: begin mask = DATA_WIDTH'(8'hFF);         sbit = sh[7];  end
      2'd1: begin mask = DATA_WIDTH'(16'hFFFF);      sbit = sh[15]; end
      2'd2: begin mask = DATA_WIDTH'(32'hFFFF_FFFF); sbit = sh[31]; end
      default: begin mask = '1; sbit = sh[DATA_WIDTH-1]; end
    endcase
  end
  assign ld_ext = (sh & mask) | ({DATA_WIDTH{sgn_r & sbit}} & ~mask);

  assign tmo    = (TIMEOUT > 0) && (tcnt == TW'(TIMEOUT - 1));
  assign done   = bus.bus_ack || tmo;
  assign fault  = bus.bus_ack ? bus.bus_err : 1'b1;
  assign fl_now = flushed || invalidate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.bus_req    <= 1'b0;
      bus.bus_we     <= 1'b0;
      bus.bus_addr   <= '0;
      bus.bus_wdata  <= '0;
      bus.bus_strb   <= '0;
      valid_out      <= 1'b0;
      load_data_out  <= '0;
      rd_address_out <= '0;
      exception_out  <= 1'b0;
      ecause_out     <= '0;
      off_r          <= '0;
      size_r         <= '0;
      sgn_r          <= 1'b0;
      st_r           <= 1'b0;
      rd_r           <= '0;
      flushed        <= 1'b0;
      tcnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stall_in) begin
            valid_out <= 1'b0;
          end else if (accept) begin
            state         <= WAIT;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= store_in;
            bus.bus_addr  <= addr_in & ~ADDR_WIDTH'(SW - 1);
            bus.bus_wdata <= store_data_in << {off, 3'b000};
            bus.bus_strb  <= strb_base << off;
            off_r         <= off;
            size_r        <= size_in;
            sgn_r         <= signed_in;
            st_r          <= store_in;
            rd_r          <= rd_address_in;
            tcnt          <= '0;
            flushed       <= 1'b0;
            valid_out     <= 1'b0;
          end else begin
            valid_out      <= valid_in && !invalidate;
            exception_out  <= pass_exc;
            ecause_out     <= pass_exc ? pass_cause : 4'd0;
            rd_address_out <= rd_address_in;
          end
        end
        WAIT: begin
          if (done) begin
            bus.bus_req    <= 1'b0;
            rd_address_out <= rd_r;
            exception_out  <= fault && !fl_now;
            ecause_out     <= fault ? (st_r ? 4'd7 : 4'd5) : 4'd0;
            if (bus.bus_ack && !st_r) load_data_out <= ld_ext;
            if (stall_in) begin
              state     <= HOLD;
              valid_out <= 1'b0;
              flushed   <= fl_now;
            end else begin
              state     <= IDLE;
              valid_out <= !fl_now;
              flushed   <= 1'b0;
            end
          end else begin
            flushed <= fl_now;
            tcnt    <= tcnt + 1'b1;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            state         <= IDLE;
            valid_out     <= !fl_now;
            exception_out <= exception_out && !fl_now;
            flushed       <= 1'b0;
          end else begin
            flushed <= fl_now;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
